pipeline_readreg_fwd: RTL and testbench

//  Parametrised register-read pipeline stage with valid/ready flow control.
//  - Latches decoded instruction fields and reads Rm/Rn/Rd from an internal multi-write-port register file.
//  - Forwards same-cycle writeback data (write-through bypass).
//  - Detects load-use hazards and inserts one bubble.

---
 rtl/pipe_pkg.sv | 12 +
 rtl/regfile_nport.sv | 69 ++++++
 rtl/pipeline_readreg_fwd.sv | 132 +++++++++++++
 tb/tb_pipeline_readreg_fwd.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions used by decode, register-read and execute.
//   CTRL_W        : width of the decoded control word
//   CTRL_LOAD_BIT : control-word bit marking a load instruction
//   ctrl_t        : decoded control word type
package pipe_pkg;

  localparam int unsigned CTRL_W        = 22;
  localparam int unsigned CTRL_LOAD_BIT = 8;

  typedef logic [CTRL_W-1:0] ctrl_t;

endpackage : pipe_pkg

// File: rtl/regfile_nport.sv
// Register file with NWP priority write ports and NRP asynchronous read ports.
// A read that matches a same-cycle write returns the write data (write-through);
// on multiple matching writes the highest port index wins, for both the stored
// value and the bypass.
// Ports:
//   clk, i_rst_n          : clock, synchronous active-low reset (clears storage)
//   i_we      [NWP]       : per-port write enable
//   i_waddr   [NWP*AW]    : per-port write register, port p at [p*AW +: AW]
//   i_wdata   [NWP*DW]    : per-port write data, port p at [p*DW +: DW]
//   i_raddr   [NRP*AW]    : read register, read port k at [k*AW +: AW]
//   o_rdata   [NRP*DW]    : read data (combinational), port k at [k*DW +: DW]
module regfile_nport #(
  parameter int unsigned DW   = 16,
  parameter int unsigned NREG = 8,
  parameter int unsigned AW   = 3,
  parameter int unsigned NWP  = 2,
  parameter int unsigned NRP  = 3
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic [NWP-1:0]    i_we,
  input  logic [NWP*AW-1:0] i_waddr,
  input  logic [NWP*DW-1:0] i_wdata,
  input  logic [NRP*AW-1:0] i_raddr,
  output logic [NRP*DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem  [NREG];
  logic [DW-1:0] w_next [NREG];

  // Next value of every entry; later ports override earlier ones.
  always_comb begin
    for (int r = 0; r < int'(NREG); r++) begin
      w_next[r] = r_mem[r];
      for (int p = 0; p < int'(NWP); p++) begin
        if (i_we[p] && (i_waddr[p*AW +: AW] == AW'(r))) begin
          w_next[r] = i_wdata[p*DW +: DW];
        end
      end
    end
  end

  // Storage; writes presented during reset are dropped.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      for (int r = 0; r < int'(NREG); r++) begin
        r_mem[r] <= '0;
      end
    end else begin
      for (int r = 0; r < int'(NREG); r++) begin
        r_mem[r] <= w_next[r];
      end
    end
  end

  // Read ports with write-through bypass.
  always_comb begin
    o_rdata = '0;
    for (int k = 0; k < int'(NRP); k++) begin
      o_rdata[k*DW +: DW] = r_mem[i_raddr[k*AW +: AW]];
      for (int p = 0; p < int'(NWP); p++) begin
        if (i_we[p] && (i_waddr[p*AW +: AW] == i_raddr[k*AW +: AW])) begin
          o_rdata[k*DW +: DW] = i_wdata[p*DW +: DW];
        end
      end
    end
  end

endmodule : regfile_nport

// File: rtl/pipeline_readreg_fwd.sv
// Register-read pipeline stage between decode and execute, valid/ready flow
// control, write-through bypass from writeback and one-bubble load-use hazard
// insertion.
// Ports:
//   clk, rst                  : clock, synchronous active-low reset
//   in_valid/in_ready         : decode handshake (in_ready combinational)
//   control_in, num_R*_in,
//   imm_in                    : decoded instruction fields
//   flush                     : kill held instruction, suppress capture
//   out_valid/out_ready       : execute handshake
//   control_out, num_R*_out,
//   imm_out                   : registered instruction fields
//   data_R*_out               : operands, combinational from regfile + bypass
//   loads                     : held instruction is a valid load
//   load_use_stall            : load-use hazard against the presented instruction
//   write_en, num_write_in,
//   data_write_in             : NWP writeback ports
module pipeline_readreg_fwd
  import pipe_pkg::*;
#(
  parameter  int unsigned DW       = 16,
  parameter  int unsigned NREG     = 8,
  localparam int unsigned AW       = $clog2(NREG),
  parameter  int unsigned CW       = CTRL_W,
  parameter  int unsigned NWP      = 2,
  parameter  int unsigned LOAD_BIT = CTRL_LOAD_BIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW-1:0]     control_in,
  input  logic [AW-1:0]     num_Rm_in,
  input  logic [AW-1:0]     num_Rn_in,
  input  logic [AW-1:0]     num_Rd_in,
  input  logic [DW-1:0]     imm_in,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [CW-1:0]     control_out,
  output logic [AW-1:0]     num_Rm_out,
  output logic [AW-1:0]     num_Rn_out,
  output logic [AW-1:0]     num_Rd_out,
  output logic [DW-1:0]     imm_out,
  output logic [DW-1:0]     data_Rm_out,
  output logic [DW-1:0]     data_Rn_out,
  output logic [DW-1:0]     data_Rd_out,
  output logic              loads,
  output logic              load_use_stall,
  input  logic [NWP-1:0]    write_en,
  input  logic [NWP*AW-1:0] num_write_in,
  input  logic [NWP*DW-1:0] data_write_in
);

  localparam int unsigned NRP = 3;

  logic          r_valid;
  logic [CW-1:0] r_ctrl;
  logic [AW-1:0] r_rm;
  logic [AW-1:0] r_rn;
  logic [AW-1:0] r_rd;
  logic [DW-1:0] r_imm;

  logic              w_loads;
  logic              w_stall;
  logic              w_in_ready;
  logic              w_capture;
  logic [NRP*AW-1:0] w_raddr;
  logic [NRP*DW-1:0] w_rdata;

  // Hazard: a held load whose destination feeds the presented instruction.
  assign w_loads    = r_valid & r_ctrl[LOAD_BIT];
  assign w_stall    = w_loads & in_valid & ((r_rd == num_Rm_in) | (r_rd == num_Rn_in));
  assign w_in_ready = (~r_valid | out_ready) & ~w_stall;
  // Flush blocks the capture but is deliberately not folded into in_ready.
  assign w_capture  = in_valid & w_in_ready & ~flush;

  // Pipeline registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_rm    <= '0;
      r_rn    <= '0;
      r_rd    <= '0;
      r_imm   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid <= 1'b1;
      r_ctrl  <= control_in;
      r_rm    <= num_Rm_in;
      r_rn    <= num_Rn_in;
      r_rd    <= num_Rd_in;
      r_imm   <= imm_in;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign w_raddr = {r_rd, r_rn, r_rm};

  regfile_nport #(
    .DW   (DW),
    .NREG (NREG),
    .AW   (AW),
    .NWP  (NWP),
    .NRP  (NRP)
  ) u_regfile (
    .clk     (clk),
    .i_rst_n (rst),
    .i_we    (write_en),
    .i_waddr (num_write_in),
    .i_wdata (data_write_in),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign in_ready       = w_in_ready;
  assign load_use_stall = w_stall;
  assign loads          = w_loads;
  assign out_valid      = r_valid;
  assign control_out    = r_ctrl;
  assign num_Rm_out     = r_rm;
  assign num_Rn_out     = r_rn;
  assign num_Rd_out     = r_rd;
  assign imm_out        = r_imm;
  assign data_Rm_out    = w_rdata[0*DW +: DW];
  assign data_Rn_out    = w_rdata[1*DW +: DW];
  assign data_Rd_out    = w_rdata[2*DW +: DW];

endmodule : pipeline_readreg_fwd

// File: tb/tb_pipeline_readreg_fwd.sv
// Bench for pipeline_readreg_fwd: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a behavioural model.
module tb_pipeline_readreg_fwd;

  localparam int unsigned DW   = 16;
  localparam int unsigned NREG = 8;
  localparam int unsigned AW   = 3;
  localparam int unsigned CW   = 22;
  localparam int unsigned NWP  = 2;
  localparam int unsigned LB   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [CW-1:0]     control_in;
  logic [AW-1:0]     num_Rm_in, num_Rn_in, num_Rd_in;
  logic [DW-1:0]     imm_in;
  logic              flush;
  logic              out_ready;
  logic              out_valid;
  logic [CW-1:0]     control_out;
  logic [AW-1:0]     num_Rm_out, num_Rn_out, num_Rd_out;
  logic [DW-1:0]     imm_out;
  logic [DW-1:0]     data_Rm_out, data_Rn_out, data_Rd_out;
  logic              loads;
  logic              load_use_stall;
  logic [NWP-1:0]    write_en;
  logic [NWP*AW-1:0] num_write_in;
  logic [NWP*DW-1:0] data_write_in;

  pipeline_readreg_fwd #(
    .DW(DW), .NREG(NREG), .CW(CW), .NWP(NWP), .LOAD_BIT(LB)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .control_in(control_in), .num_Rm_in(num_Rm_in), .num_Rn_in(num_Rn_in),
    .num_Rd_in(num_Rd_in), .imm_in(imm_in), .flush(flush),
    .out_ready(out_ready), .out_valid(out_valid), .control_out(control_out),
    .num_Rm_out(num_Rm_out), .num_Rn_out(num_Rn_out), .num_Rd_out(num_Rd_out),
    .imm_out(imm_out), .data_Rm_out(data_Rm_out), .data_Rn_out(data_Rn_out),
    .data_Rd_out(data_Rd_out), .loads(loads), .load_use_stall(load_use_stall),
    .write_en(write_en), .num_write_in(num_write_in), .data_write_in(data_write_in)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Behavioural model: the held instruction as a record plus an array of registers.
  logic          m_valid = 1'b0;
  logic [CW-1:0] m_ctrl  = '0;
  logic [AW-1:0] m_rm = '0, m_rn = '0, m_rd = '0;
  logic [DW-1:0] m_imm   = '0;
  logic [DW-1:0] m_regs [NREG];

  wire m_is_load = m_valid && m_ctrl[LB];
  wire m_stall   = m_is_load && in_valid && (m_rd == num_Rm_in || m_rd == num_Rn_in);
  wire m_rdy     = (!m_valid || out_ready) && !m_stall;

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = m_regs[a];
    for (int p = 0; p < int'(NWP); p++)
      if (write_en[p] && num_write_in[p*AW +: AW] == a) v = data_write_in[p*DW +: DW];
    return v;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_valid <= 1'b0;
      m_ctrl  <= '0;
      m_rm    <= '0;
      m_rn    <= '0;
      m_rd    <= '0;
      m_imm   <= '0;
      for (int r = 0; r < int'(NREG); r++) m_regs[r] <= '0;
    end else begin
      for (int p = 0; p < int'(NWP); p++)
        if (write_en[p]) m_regs[num_write_in[p*AW +: AW]] <= data_write_in[p*DW +: DW];
      if (flush) m_valid <= 1'b0;
      else if (in_valid && m_rdy) begin
        m_valid <= 1'b1;
        m_ctrl  <= control_in;
        m_rm    <= num_Rm_in;
        m_rn    <= num_Rn_in;
        m_rd    <= num_Rd_in;
        m_imm   <= imm_in;
      end else if (out_ready) m_valid <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid",      32'(out_valid),      32'(m_valid));
      chk("in_ready",       32'(in_ready),       32'(m_rdy));
      chk("load_use_stall", 32'(load_use_stall), 32'(m_stall));
      chk("loads",          32'(loads),          32'(m_is_load));
      chk("control_out",    32'(control_out),    32'(m_ctrl));
      chk("num_Rm_out",     32'(num_Rm_out),     32'(m_rm));
      chk("num_Rn_out",     32'(num_Rn_out),     32'(m_rn));
      chk("num_Rd_out",     32'(num_Rd_out),     32'(m_rd));
      chk("imm_out",        32'(imm_out),        32'(m_imm));
      chk("data_Rm_out",    32'(data_Rm_out),    32'(exp_read(m_rm)));
      chk("data_Rn_out",    32'(data_Rn_out),    32'(exp_read(m_rn)));
      chk("data_Rd_out",    32'(data_Rd_out),    32'(exp_read(m_rd)));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [CW-1:0] c, input logic [AW-1:0] rm, input logic [AW-1:0] rn,
                       input logic [AW-1:0] rd, input logic [DW-1:0] imm);
    in_valid = 1'b1; control_in = c; num_Rm_in = rm; num_Rn_in = rn; num_Rd_in = rd; imm_in = imm;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; control_in = '0; num_Rm_in = '0; num_Rn_in = '0; num_Rd_in = '0;
    imm_in = '0; flush = 1'b0; out_ready = 1'b0; write_en = '0; num_write_in = '0; data_write_in = '0;

    // Reset held for two edges.
    cyc(); cyc();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst out_valid", 32'(out_valid), 32'h0);
    chk("rst control_out", 32'(control_out), 32'h0);
    chk("rst imm_out", 32'(imm_out), 32'h0);
    cyc();
    rst = 1'b1; out_ready = 1'b1;
    instr('0, '0, '0, '0, '0);
    // Read every register after reset.
    for (int i = 0; i < int'(NREG); i++) begin
      cyc();
      if (i == int'(NREG) - 1) in_valid = 1'b0;
      else instr('0, AW'(i + 1), AW'(i + 1), AW'(i + 1), '0);
      @(negedge clk);
      chk("rd num_Rm_out", 32'(num_Rm_out), 32'(i));
      chk("rd data_Rm_out", 32'(data_Rm_out), 32'h0);
      chk("rd data_Rd_out", 32'(data_Rd_out), 32'h0);
    end

    // Bypass: both ports write R3, highest port wins.
    cyc();
    instr('0, 3'd3, 3'd1, 3'd0, 16'h0003);
    cyc();
    in_valid = 1'b0; out_ready = 1'b0;
    write_en = 2'b11; num_write_in = {3'd3, 3'd3}; data_write_in = {16'h2222, 16'h1111};
    @(negedge clk);
    chk("bypass data_Rm_out", 32'(data_Rm_out), 32'h2222);
    cyc();
    write_en = '0;
    @(negedge clk);
    chk("stored R3", 32'(data_Rm_out), 32'h2222);

    // Backpressure.
    cyc();
    out_ready = 1'b1;
    instr(22'h0000A5, 3'd1, 3'd2, 3'd4, 16'hAAAA);
    cyc();
    out_ready = 1'b0;
    instr(22'h001234, 3'd5, 3'd6, 3'd7, 16'hBBBB);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp in_ready", 32'(in_ready), 32'h0);
      chk("bp imm_out", 32'(imm_out), 32'hAAAA);
      cyc();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp release in_ready", 32'(in_ready), 32'h1);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp B imm_out", 32'(imm_out), 32'hBBBB);
    chk("bp B control_out", 32'(control_out), 32'h001234);

    // Load-use: LDR R2 followed by ADD reading R2.
    cyc();
    instr(22'h000100, 3'd0, 3'd0, 3'd2, 16'h0001);
    cyc();
    instr(22'h000000, 3'd2, 3'd5, 3'd3, 16'h0ADD);
    @(negedge clk);
    chk("lu stall", 32'(load_use_stall), 32'h1);
    chk("lu in_ready", 32'(in_ready), 32'h0);
    cyc();
    @(negedge clk);
    chk("lu bubble out_valid", 32'(out_valid), 32'h0);
    cyc();
    @(negedge clk);
    chk("lu consumer out_valid", 32'(out_valid), 32'h1);
    chk("lu consumer imm_out", 32'(imm_out), 32'h0ADD);

    // Flush with a concurrent write.
    cyc();
    flush = 1'b1;
    instr('0, 3'd6, 3'd0, 3'd0, 16'hCCCC);
    write_en = 2'b01; num_write_in = {3'd0, 3'd6}; data_write_in = {16'h0000, 16'hABCD};
    cyc();
    flush = 1'b0; in_valid = 1'b0; write_en = '0;
    @(negedge clk);
    chk("flush out_valid", 32'(out_valid), 32'h0);
    chk("flush imm_out", 32'(imm_out), 32'h0ADD);
    cyc();
    out_ready = 1'b0;
    instr('0, 3'd6, 3'd6, 3'd0, 16'h6666);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush write R6", 32'(data_Rm_out), 32'hABCD);

    // Reset while holding a valid instruction with a write pending.
    cyc();
    rst = 1'b0;
    write_en = 2'b01; num_write_in = {3'd0, 3'd1}; data_write_in = {16'h0000, 16'h5555};
    cyc();
    rst = 1'b1; write_en = '0; out_ready = 1'b1;
    instr('0, 3'd1, 3'd6, 3'd0, 16'h0000);
    @(negedge clk);
    chk("mid rst out_valid", 32'(out_valid), 32'h0);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid rst R1", 32'(data_Rm_out), 32'h0);
    chk("mid rst R6", 32'(data_Rn_out), 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      cyc();
      rst        = ($urandom_range(0, 63) != 0);
      flush      = ($urandom_range(0, 7) == 0);
      in_valid   = $urandom_range(0, 1) == 1;
      out_ready  = ($urandom_range(0, 9) < 7);
      control_in = CW'($urandom);
      control_in[LB] = ($urandom_range(0, 9) < 4);
      num_Rm_in  = AW'($urandom);
      num_Rn_in  = AW'($urandom);
      num_Rd_in  = AW'($urandom);
      imm_in     = DW'($urandom);
      write_en   = NWP'($urandom);
      num_write_in  = (NWP*AW)'($urandom);
      data_write_in = (NWP*DW)'($urandom);
    end
    cyc();
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_pipeline_readreg_fwd
